// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared state encoding, default parameters and counter sizing for the TRNG controller
package trng_pkg;

  typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, FAIL} state_t;

  localparam int TRIM_BITS_DEF     = 26;
  localparam int WORD_W_DEF        = 32;
  localparam int WARMUP_CYCLES_DEF = 1024;
  localparam int SAMPLE_DIV_DEF    = 16;
  localparam int RCT_LIMIT_DEF     = 32;

  // Width of a counter that must hold every value 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/trng_health_rct.sv
// rtl/trng_health_rct.sv - repetition-count health test on the raw entropy samples
// Raises a one-cycle alarm on the strobe that brings the identical-sample run up to RCT_LIMIT.
module trng_health_rct
  import trng_pkg::*;
#(
  parameter int RCT_LIMIT = RCT_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic strobe,
  input  logic sample,
  output logic alarm
);

  localparam int RW = cnt_w(RCT_LIMIT);
  localparam logic [RW-1:0] LIM = RW'(RCT_LIMIT);
  localparam logic [RW-1:0] ONE = RW'(1);

  logic [RW-1:0] run;
  logic [RW-1:0] run_next;
  logic          last;

  // A run of zero means no sample seen since clear, so the next one starts a run of 1.
  always_comb begin
    run_next = ONE;
    if (run != '0 && sample == last) begin
      run_next = (run == LIM) ? LIM : run + ONE;
    end
    alarm = strobe && !clear && (run_next == LIM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      run  <= '0;
      last <= 1'b0;
    end else if (strobe) begin
      run  <= run_next;
      last <= sample;
    end
  end

endmodule

// File: rtl/trng_ctrl.sv
// rtl/trng_ctrl.sv - ring-oscillator TRNG sequencer, sampler, word packer and output handshake
// Optional von Neumann debiasing of the sampled stream when TRNG_VN_DEBIAS_EN is defined.
module trng_ctrl
  import trng_pkg::*;
#(
  parameter int TRIM_BITS     = TRIM_BITS_DEF,
  parameter int WORD_W        = WORD_W_DEF,
  parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF,
  parameter int SAMPLE_DIV    = SAMPLE_DIV_DEF,
  parameter int RCT_LIMIT     = RCT_LIMIT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [TRIM_BITS-1:0] trim_fast_i,
  input  logic [TRIM_BITS-1:0] trim_slow_i,
  output logic                 ro_rst_o,
  output logic [TRIM_BITS-1:0] ro_trim_fast_o,
  output logic [TRIM_BITS-1:0] ro_trim_slow_o,
  input  logic                 ro_trng_i,
  output logic [WORD_W-1:0]    rnd_data_o,
  output logic                 rnd_valid_o,
  input  logic                 rnd_ready_i,
  output logic                 busy_o,
  output logic                 alarm_o
);

  localparam int WCW = cnt_w(WARMUP_CYCLES);
  localparam int DVW = cnt_w(SAMPLE_DIV);
  localparam int BCW = cnt_w(WORD_W);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(SAMPLE_DIV - 1);
  localparam logic [BCW-1:0] WORD_FULL = BCW'(WORD_W);

  state_t            state;
  logic              sync1, sync2;
  logic [WCW-1:0]    warm_cnt;
  logic [DVW-1:0]    div;
  logic [BCW-1:0]    bitcnt;
  logic [WORD_W-1:0] shreg;
  logic              strobe, rct_alarm, emit, emit_bit, load;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ro_trng_i;
      sync2 <= sync1;
    end
  end

  assign strobe = (state == COLLECT) && (div == DIV_LAST);
  assign load   = (bitcnt == WORD_FULL) && (!rnd_valid_o || rnd_ready_i);

  trng_health_rct #(.RCT_LIMIT(RCT_LIMIT)) u_rct (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (state != COLLECT),
    .strobe (strobe),
    .sample (sync2),
    .alarm  (rct_alarm)
  );

`ifdef TRNG_VN_DEBIAS_EN
  logic pair_half, first_bit;

  // Pairing restarts on every entry to COLLECT so words never straddle a restart.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || state != COLLECT) begin
      pair_half <= 1'b0;
      first_bit <= 1'b0;
    end else if (strobe) begin
      pair_half <= !pair_half;
      first_bit <= sync2;
    end
  end

  assign emit     = strobe && pair_half && (first_bit != sync2);
  assign emit_bit = first_bit;
`else
  assign emit     = strobe;
  assign emit_bit = sync2;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= IDLE;
      ro_rst_o       <= 1'b1;
      ro_trim_fast_o <= '0;
      ro_trim_slow_o <= '0;
      rnd_data_o     <= '0;
      rnd_valid_o    <= 1'b0;
      busy_o         <= 1'b0;
      alarm_o        <= 1'b0;
      warm_cnt       <= '0;
      div            <= '0;
      bitcnt         <= '0;
      shreg          <= '0;
    end else begin
      case (state)
        IDLE: begin
          ro_rst_o       <= 1'b1;
          ro_trim_fast_o <= trim_fast_i;
          ro_trim_slow_o <= trim_slow_i;
          rnd_valid_o    <= 1'b0;
          bitcnt         <= '0;
          shreg          <= '0;
          if (en_i) begin
            state    <= WARMUP;
            warm_cnt <= '0;
            ro_rst_o <= 1'b0;
            busy_o   <= 1'b1;
          end
        end
        WARMUP: begin
          if (!en_i) begin
            state    <= IDLE;
            ro_rst_o <= 1'b1;
            busy_o   <= 1'b0;
          end else if (warm_cnt == WARM_LAST) begin
            state  <= COLLECT;
            div    <= '0;
            bitcnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        COLLECT: begin
          if (!en_i) begin
            state       <= IDLE;
            ro_rst_o    <= 1'b1;
            busy_o      <= 1'b0;
            rnd_valid_o <= 1'b0;
            bitcnt      <= '0;
            shreg       <= '0;
          end else if (rct_alarm) begin
            state       <= FAIL;
            ro_rst_o    <= 1'b1;
            rnd_valid_o <= 1'b0;
            alarm_o     <= 1'b1;
          end else begin
            div <= strobe ? '0 : div + 1'b1;
            // A completed word waits in shreg until the output register frees up.
            if (load) begin
              rnd_data_o  <= shreg;
              rnd_valid_o <= 1'b1;
              bitcnt      <= '0;
            end else if (rnd_valid_o && rnd_ready_i) begin
              rnd_valid_o <= 1'b0;
            end
            if (emit && bitcnt != WORD_FULL) begin
              shreg  <= {emit_bit, shreg[WORD_W-1:1]};
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        FAIL: begin
          ro_rst_o    <= 1'b1;
          rnd_valid_o <= 1'b0;
          if (!en_i) begin
            state   <= IDLE;
            alarm_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_ctrl.sv
// tb/tb_trng_ctrl.sv - directed self-checking bench for trng_ctrl (small parameter set)
module tb_trng_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic [25:0] trim_fast_i = '0;
  logic [25:0] trim_slow_i = '0;
  logic        ro_trng_i = 1'b0;
  logic        rnd_ready_i = 1'b0;
  logic        ro_rst_o;
  logic [25:0] ro_trim_fast_o;
  logic [25:0] ro_trim_slow_o;
  logic [7:0]  rnd_data_o;
  logic        rnd_valid_o;
  logic        busy_o;
  logic        alarm_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sidx = 0;
  logic [255:0] stream = '0;

  trng_ctrl #(
    .TRIM_BITS(26), .WORD_W(8), .WARMUP_CYCLES(8), .SAMPLE_DIV(4), .RCT_LIMIT(6)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i),
    .trim_fast_i(trim_fast_i), .trim_slow_i(trim_slow_i),
    .ro_rst_o(ro_rst_o), .ro_trim_fast_o(ro_trim_fast_o), .ro_trim_slow_o(ro_trim_slow_o),
    .ro_trng_i(ro_trng_i), .rnd_data_o(rnd_data_o), .rnd_valid_o(rnd_valid_o),
    .rnd_ready_i(rnd_ready_i), .busy_o(busy_o), .alarm_o(alarm_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples are taken on edges 12,16,20,... after en_i is seen; the next raw bit is
  // presented right after each of those edges so it clears the synchroniser in time.
  task automatic step();
    tick();
    cyc++;
    if (cyc >= 12 && (cyc - 12) % 4 == 0) begin
      sidx++;
      ro_trng_i = stream[sidx];
    end
  endtask

  task automatic start_run(input logic [255:0] s);
    stream = s;
    sidx = 0;
    ro_trng_i = s[0];
    en_i = 1'b0;
    repeat (3) tick();
    en_i = 1'b1;
    tick();
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b0;
    trim_fast_i = 26'h155; trim_slow_i = 26'h2AA;
    tick(); tick();
    checks++; if (ro_rst_o !== 1'b1) begin errors++; $display("FAIL rst_ro_rst: got %b exp 1", ro_rst_o); end
    checks++; if (ro_trim_fast_o !== 26'h0) begin errors++; $display("FAIL rst_trim: got %h exp 0", ro_trim_fast_o); end
    checks++; if (rnd_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", rnd_valid_o); end
    checks++; if (rnd_data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", rnd_data_o); end
    checks++; if ({busy_o, alarm_o} !== 2'b00) begin errors++; $display("FAIL rst_busy_alarm: got %b exp 00", {busy_o, alarm_o}); end
    rst_ni = 1'b1;
    tick();
    checks++; if (ro_trim_fast_o !== 26'h155) begin errors++; $display("FAIL idle_trim_fast: got %h exp 155", ro_trim_fast_o); end
    checks++; if (ro_trim_slow_o !== 26'h2AA) begin errors++; $display("FAIL idle_trim_slow: got %h exp 2aa", ro_trim_slow_o); end
    checks++; if (ro_rst_o !== 1'b1) begin errors++; $display("FAIL idle_ro_rst: got %b exp 1", ro_rst_o); end
  endtask

  task automatic test_first_word();
    logic early;
    start_run({216'd0, 8'h69, 8'h55, 8'hAA, 8'h36, 8'h4D});
    checks++; if ({ro_rst_o, busy_o} !== 2'b01) begin errors++; $display("FAIL warm_rst_busy: got %b exp 01", {ro_rst_o, busy_o}); end
    trim_fast_i = 26'h3;
    step();
    checks++; if (ro_trim_fast_o !== 26'h155) begin errors++; $display("FAIL trim_frozen: got %h exp 155", ro_trim_fast_o); end
    early = 1'b0;
    while (cyc < 40) begin
      step();
      if (rnd_valid_o !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL first_valid_early: got %b exp 0", early); end
    step();
    checks++; if (rnd_valid_o !== 1'b1) begin errors++; $display("FAIL first_valid: got %b exp 1", rnd_valid_o); end
    checks++; if (rnd_data_o !== 8'h4D) begin errors++; $display("FAIL first_data: got %h exp 4d", rnd_data_o); end
  endtask

  task automatic test_backpressure();
    run_to(137);
    checks++; if (rnd_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b exp 1", rnd_valid_o); end
    checks++; if (rnd_data_o !== 8'h4D) begin errors++; $display("FAIL hold_data: got %h exp 4d", rnd_data_o); end
    rnd_ready_i = 1'b1;
    step();
    checks++; if ({rnd_valid_o, rnd_data_o} !== {1'b1, 8'h36}) begin errors++; $display("FAIL accept_load: got %b/%h exp 1/36", rnd_valid_o, rnd_data_o); end
    step();
    checks++; if (rnd_valid_o !== 1'b0) begin errors++; $display("FAIL accept_drain: got %b exp 0", rnd_valid_o); end
    run_to(168);
    checks++; if (rnd_valid_o !== 1'b0) begin errors++; $display("FAIL third_early: got %b exp 0", rnd_valid_o); end
    step();
    checks++; if ({rnd_valid_o, rnd_data_o} !== {1'b1, 8'h69}) begin errors++; $display("FAIL third_word: got %b/%h exp 1/69", rnd_valid_o, rnd_data_o); end
    en_i = 1'b0;
    tick();
    checks++; if ({busy_o, rnd_valid_o, ro_rst_o} !== 3'b001) begin errors++; $display("FAIL disable_idle: got %b exp 001", {busy_o, rnd_valid_o, ro_rst_o}); end
  endtask

  task automatic test_rct();
    start_run('1);
    run_to(31);
    checks++; if ({alarm_o, busy_o} !== 2'b01) begin errors++; $display("FAIL rct_before: got %b exp 01", {alarm_o, busy_o}); end
    step();
    checks++; if ({alarm_o, ro_rst_o, rnd_valid_o} !== 3'b110) begin errors++; $display("FAIL rct_trip: got %b exp 110", {alarm_o, ro_rst_o, rnd_valid_o}); end
    repeat (4) step();
    checks++; if ({alarm_o, busy_o} !== 2'b11) begin errors++; $display("FAIL rct_sticky: got %b exp 11", {alarm_o, busy_o}); end
    en_i = 1'b0;
    tick();
    checks++; if ({alarm_o, busy_o, ro_rst_o} !== 3'b001) begin errors++; $display("FAIL rct_exit: got %b exp 001", {alarm_o, busy_o, ro_rst_o}); end
  endtask

  task automatic test_disable_midway();
    logic early;
    start_run({248'd0, 8'h0F});
    run_to(29);
    en_i = 1'b0;
    tick();
    checks++; if ({busy_o, rnd_valid_o, ro_rst_o} !== 3'b001) begin errors++; $display("FAIL mid_disable: got %b exp 001", {busy_o, rnd_valid_o, ro_rst_o}); end
    start_run({248'd0, 8'hC6});
    checks++; if (ro_rst_o !== 1'b0) begin errors++; $display("FAIL rerun_ro_rst: got %b exp 0", ro_rst_o); end
    early = 1'b0;
    while (cyc < 40) begin
      step();
      if (rnd_valid_o !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL rerun_early: got %b exp 0", early); end
    step();
    checks++; if ({rnd_valid_o, rnd_data_o} !== {1'b1, 8'hC6}) begin errors++; $display("FAIL rerun_word: got %b/%h exp 1/c6", rnd_valid_o, rnd_data_o); end
    en_i = 1'b0;
    tick();
  endtask

`ifdef TRNG_VN_DEBIAS_EN
  task automatic test_debias();
    logic early;
    // Raw pairs 01,11,10,00,10,01,10,01,10,10 emit 0,1,1,0,1,0,1,1.
    start_run({236'd0, 20'b0101_1001_1001_0001_1110});
    early = 1'b0;
    while (cyc < 88) begin
      step();
      if (rnd_valid_o !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL vn_early: got %b exp 0", early); end
    step();
    checks++; if ({rnd_valid_o, rnd_data_o} !== {1'b1, 8'hD6}) begin errors++; $display("FAIL vn_word: got %b/%h exp 1/d6", rnd_valid_o, rnd_data_o); end
    en_i = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_first_word();
    test_backpressure();
    test_rct();
    test_disable_midway();
`ifdef TRNG_VN_DEBIAS_EN
    test_debias();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
